// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Saturate an out-of-range preset digit to 9 so no non-BCD value is ever loaded.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Combinational single-digit BCD decrementer; wraps 0 -> 9 and raises borrow_out.
module bcd_digit_down
  import timer_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t digit_next,
  output logic       borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (00-99) with a clock prescaler and IDLE/RUN/PAUSED/DONE control.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_TICK = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned PRESCALE_W = $clog2(CYCLES_PER_TICK);
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(CYCLES_PER_TICK - 1);

  timer_state_t          state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  bcd_digit_t            tens_q, tens_d;
  bcd_digit_t            units_q, units_d;
  logic                  expired_q, expired_d;
  logic                  running_q, done_q;

  bcd_digit_t            units_dec, tens_dec;
  bcd_digit_t            load_tens, load_units;
  logic                  units_borrow, tens_borrow;

  bcd_digit_down u_units_dec (
    .digit      (units_q),
    .borrow_in  (1'b1),
    .digit_next (units_dec),
    .borrow_out (units_borrow)
  );

  bcd_digit_down u_tens_dec (
    .digit      (tens_q),
    .borrow_in  (units_borrow),
    .digit_next (tens_dec),
    .borrow_out (tens_borrow)
  );

  assign load_tens  = bcd_clamp(preset_tens);
  assign load_units = bcd_clamp(preset_units);

  // Next-state logic: start overrides everything; RUN and un-paused PAUSED count identically.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tens_d    = tens_q;
    units_d   = units_q;
    expired_d = 1'b0;

    if (start) begin
      tens_d  = load_tens;
      units_d = load_units;
      presc_d = '0;
      if ((load_tens == 4'd0) && (load_units == 4'd0)) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end else if (pause) begin
        state_d = PAUSED;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (presc_q == PRESCALE_LAST) begin
              presc_d = '0;
              // A borrow out of the tens digit would mean counting below 00; never let it through.
              if (!tens_borrow) begin
                tens_d  = tens_dec;
                units_d = units_dec;
                if ((tens_dec == 4'd0) && (units_dec == 4'd0)) begin
                  state_d   = DONE;
                  expired_d = 1'b1;
                end
              end
            end else begin
              presc_d = presc_q + PRESCALE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      expired_q <= expired_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
